// File: rtl/idma_stream_sched.sv
// Round-robin scheduler that forwards NumStreams iDMA request streams to one backend and tracks per-stream IDs.
// Define IDMA_STREAM_SCHED_PRIO_EN to give stream 0 strict priority; the other streams then share round-robin.
module idma_stream_sched #(
  parameter int unsigned  NumStreams     = 4,
  parameter int unsigned  IdCounterWidth = 32,
  parameter int unsigned  MaxOutstanding = 8,
  parameter type          dma_req_t      = logic,
  localparam int unsigned StreamWidth    = (NumStreams > 1) ? $clog2(NumStreams) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  dma_req_t [NumStreams-1:0]                 req_i,
  input  logic [NumStreams-1:0]                     req_valid_i,
  output logic [NumStreams-1:0]                     req_ready_o,
  output dma_req_t                                  req_o,
  output logic                                      req_valid_o,
  input  logic                                      req_ready_i,
  output logic [StreamWidth-1:0]                    req_stream_o,
  output logic [IdCounterWidth-1:0]                 req_id_o,
  input  logic                                      cmpl_valid_i,
  input  logic [StreamWidth-1:0]                    cmpl_stream_i,
  output logic [NumStreams-1:0][IdCounterWidth-1:0] next_id_o,
  output logic [NumStreams-1:0][IdCounterWidth-1:0] done_id_o,
  output logic [NumStreams-1:0]                     busy_o,
  output logic                                      err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  typedef logic [CntWidth-1:0]      cnt_t;
  typedef logic [StreamWidth:0]     idx_ext_t;
  typedef logic [IdCounterWidth-1:0] id_t;

  localparam idx_ext_t NumStreamsExt = idx_ext_t'(NumStreams);
  localparam cnt_t     MaxOut        = cnt_t'(MaxOutstanding);

  typedef enum logic {ARB_FREE, ARB_LOCKED} arb_state_e;

  arb_state_e                         arb_state_q;
  logic [StreamWidth-1:0]             lock_stream_q;
  logic [StreamWidth-1:0]             rr_ptr_q;
  cnt_t [NumStreams-1:0]              outst_q;
  cnt_t [NumStreams-1:0]              outst_d;
  logic [NumStreams-1:0][IdCounterWidth-1:0] next_id_q;
  logic [NumStreams-1:0][IdCounterWidth-1:0] done_id_q;
  logic [NumStreams-1:0]              busy_q;
  logic                               err_q;

  logic [NumStreams-1:0]              eligible;
  logic [NumStreams-1:0]              rr_cand;
  logic [NumStreams-1:0]              grant_hs;
  logic [NumStreams-1:0]              cmpl_ok;
  logic [StreamWidth-1:0]             arb_idx;
  logic [StreamWidth-1:0]             grant;
  logic [StreamWidth-1:0]             rr_next;
  logic                               arb_found;
  logic                               any_eligible;
  logic                               handshake;
  logic                               cmpl_err;

  // ID 0 is reserved, so the counter skips it when wrapping.
  function automatic id_t id_succ(input id_t id);
    return (&id) ? id_t'(1) : id + id_t'(1);
  endfunction

  always_comb begin
    eligible = '0;
    for (int s = 0; s < NumStreams; s++) begin
      eligible[s] = req_valid_i[s] && (outst_q[s] < MaxOut);
    end
  end

  assign any_eligible = |eligible;

  always_comb begin
    idx_ext_t cand;
    cand      = '0;
    rr_cand   = eligible;
`ifdef IDMA_STREAM_SCHED_PRIO_EN
    rr_cand[0] = 1'b0;
`endif
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NumStreams; i++) begin
      cand = {1'b0, rr_ptr_q} + idx_ext_t'(i);
      if (cand >= NumStreamsExt) cand = cand - NumStreamsExt;
      if (!arb_found && rr_cand[cand[StreamWidth-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[StreamWidth-1:0];
      end
    end
  end

  // A stalled grant is held so the backend sees a stable request until it accepts it.
  always_comb begin
    grant = arb_idx;
`ifdef IDMA_STREAM_SCHED_PRIO_EN
    if (eligible[0]) grant = '0;
`endif
    if (arb_state_q == ARB_LOCKED && eligible[lock_stream_q]) grant = lock_stream_q;
  end

  always_comb begin
    idx_ext_t rr_ext;
    rr_ext = {1'b0, grant} + idx_ext_t'(1);
    if (rr_ext >= NumStreamsExt) rr_ext = '0;
    rr_next = rr_ext[StreamWidth-1:0];
  end

  assign req_valid_o  = rst_ni && any_eligible;
  assign handshake    = req_valid_o && req_ready_i;
  assign req_o        = req_i[grant];
  assign req_stream_o = grant;
  assign req_id_o     = next_id_q[grant];

  always_comb begin
    req_ready_o = '0;
    grant_hs    = '0;
    if (req_valid_o) req_ready_o[grant] = req_ready_i;
    if (handshake) grant_hs[grant] = 1'b1;
  end

  // Completions on idle or nonexistent streams are rejected and reported instead of corrupting counts.
  always_comb begin
    cmpl_ok = '0;
    outst_d = outst_q;
    for (int s = 0; s < NumStreams; s++) begin
      cmpl_ok[s] = cmpl_valid_i && (cmpl_stream_i == StreamWidth'(s)) && (outst_q[s] != '0);
      if (grant_hs[s] && !cmpl_ok[s]) begin
        outst_d[s] = outst_q[s] + cnt_t'(1);
      end else if (!grant_hs[s] && cmpl_ok[s]) begin
        outst_d[s] = outst_q[s] - cnt_t'(1);
      end
    end
  end

  assign cmpl_err = cmpl_valid_i && !(|cmpl_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arb_state_q   <= ARB_FREE;
      lock_stream_q <= '0;
      rr_ptr_q      <= '0;
      outst_q       <= '0;
      busy_q        <= '0;
      err_q         <= 1'b0;
      done_id_q     <= '0;
      for (int s = 0; s < NumStreams; s++) begin
        next_id_q[s] <= id_t'(1);
      end
    end else begin
      arb_state_q <= (req_valid_o && !req_ready_i) ? ARB_LOCKED : ARB_FREE;
      if (req_valid_o) lock_stream_q <= grant;
      if (handshake) begin
`ifdef IDMA_STREAM_SCHED_PRIO_EN
        if (grant != '0) rr_ptr_q <= rr_next;
`else
        rr_ptr_q <= rr_next;
`endif
      end
      outst_q <= outst_d;
      err_q   <= cmpl_err;
      for (int s = 0; s < NumStreams; s++) begin
        busy_q[s] <= (outst_d[s] != '0);
        if (grant_hs[s]) next_id_q[s] <= id_succ(next_id_q[s]);
        if (cmpl_ok[s]) done_id_q[s] <= id_succ(done_id_q[s]);
      end
    end
  end

  assign next_id_o = next_id_q;
  assign done_id_o = done_id_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_idma_stream_sched.sv
// Bench for idma_stream_sched: directed vector table, corner-case sequences and randomized
// traffic compared against a transaction-level model of the scheduler.
module tb_idma_stream_sched;

  localparam int N      = 4;
  localparam int W      = 4;
  localparam int MaxOut = 2;

  typedef logic [15:0] req_t;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  req_t [N-1:0]         req_i;
  logic [N-1:0]         req_valid_i;
  logic [N-1:0]         req_ready_o;
  req_t                 req_o;
  logic                 req_valid_o;
  logic                 req_ready_i;
  logic [1:0]           req_stream_o;
  logic [W-1:0]         req_id_o;
  logic                 cmpl_valid_i;
  logic [1:0]           cmpl_stream_i;
  logic [N-1:0][W-1:0]  next_id_o;
  logic [N-1:0][W-1:0]  done_id_o;
  logic [N-1:0]         busy_o;
  logic                 err_o;

  idma_stream_sched #(
    .NumStreams    (N),
    .IdCounterWidth(W),
    .MaxOutstanding(MaxOut),
    .dma_req_t     (req_t)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_o        (req_o),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_stream_o (req_stream_o),
    .req_id_o     (req_id_o),
    .cmpl_valid_i (cmpl_valid_i),
    .cmpl_stream_i(cmpl_stream_i),
    .next_id_o    (next_id_o),
    .done_id_o    (done_id_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  int m_out[N];
  int m_nid[N];
  int m_did[N];
  int m_rr;
  bit m_lock;
  int m_lock_s;
  bit m_err;
  bit e_valid;
  int e_grant;

  logic         s_valid;
  logic [1:0]   s_stream;
  logic [W-1:0] s_id;
  req_t         s_req;
  logic [N-1:0] s_ready;
  logic         s_err;

  typedef struct {
    logic [N-1:0] valid;
    logic         ready;
    logic         cv;
    logic [1:0]   cs;
    logic         e_valid;
    logic [1:0]   e_grant;
    logic [W-1:0] e_id;
  } vec_t;

  vec_t tbl[11];

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int succ(input int x);
    return (x == (1 << W) - 1) ? 1 : x + 1;
  endfunction

  function automatic bit elig(input int s);
    return req_valid_i[s] && (m_out[s] < MaxOut);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < N; s++) begin
      m_out[s] = 0;
      m_nid[s] = 1;
      m_did[s] = 0;
    end
    m_rr     = 0;
    m_lock   = 0;
    m_lock_s = 0;
    m_err    = 0;
  endfunction

  function automatic void model_comb();
    int s;
    e_valid = 0;
    e_grant = 0;
    if (m_lock && elig(m_lock_s)) begin
      e_valid = 1;
      e_grant = m_lock_s;
      return;
    end
`ifdef IDMA_STREAM_SCHED_PRIO_EN
    if (elig(0)) begin
      e_valid = 1;
      e_grant = 0;
      return;
    end
`endif
    for (int k = 0; k < N; k++) begin
      s = (m_rr + k) % N;
`ifdef IDMA_STREAM_SCHED_PRIO_EN
      if (s == 0) continue;
`endif
      if (!e_valid && elig(s)) begin
        e_valid = 1;
        e_grant = s;
      end
    end
  endfunction

  function automatic void model_update();
    bit hs;
    bit legal;
    int c;
    c     = int'(cmpl_stream_i);
    hs    = e_valid && req_ready_i;
    legal = cmpl_valid_i && (c < N) && (m_out[c] > 0);
    m_err = cmpl_valid_i && !legal;
    if (hs) begin
      m_nid[e_grant] = succ(m_nid[e_grant]);
      m_out[e_grant]++;
`ifdef IDMA_STREAM_SCHED_PRIO_EN
      if (e_grant != 0) m_rr = (e_grant + 1) % N;
`else
      m_rr = (e_grant + 1) % N;
`endif
    end
    if (legal) begin
      m_out[c]--;
      m_did[c] = succ(m_did[c]);
    end
    m_lock   = e_valid && !req_ready_i;
    m_lock_s = e_grant;
  endfunction

  task automatic checkOutput();
    logic [N-1:0]        exp_rdy;
    logic [N-1:0]        exp_busy;
    logic [N-1:0][W-1:0] exp_nid;
    logic [N-1:0][W-1:0] exp_did;
    s_valid  = req_valid_o;
    s_stream = req_stream_o;
    s_id     = req_id_o;
    s_req    = req_o;
    s_ready  = req_ready_o;
    s_err    = err_o;
    exp_rdy  = '0;
    if (e_valid && req_ready_i) exp_rdy[e_grant] = 1'b1;
    for (int s = 0; s < N; s++) begin
      exp_busy[s] = (m_out[s] != 0);
      exp_nid[s]  = m_nid[s][W-1:0];
      exp_did[s]  = m_did[s][W-1:0];
    end
    compare("req_valid_o", req_valid_o, e_valid);
    if (e_valid) begin
      compare("req_stream_o", req_stream_o, e_grant);
      compare("req_id_o", req_id_o, m_nid[e_grant][W-1:0]);
      compare("req_o", req_o, req_i[e_grant]);
    end
    compare("req_ready_o", req_ready_o, exp_rdy);
    compare("busy_o", busy_o, exp_busy);
    compare("err_o", err_o, m_err);
    compare("next_id_o", next_id_o, exp_nid);
    compare("done_id_o", done_id_o, exp_did);
  endtask

  // Called at posedge+1; leaves time at the next posedge+1.
  task automatic applyStimulus(input logic [N-1:0] v, input logic rdy, input logic cv, input logic [1:0] cs);
    req_valid_i   = v;
    req_ready_i   = rdy;
    cmpl_valid_i  = cv;
    cmpl_stream_i = cs;
    @(negedge clk_i);
    model_comb();
    checkOutput();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic doReset();
    rst_ni      = 1'b0;
    req_valid_i = '1;
    req_ready_i = 1'b1;
    #2;
    compare("rst_req_valid_o", req_valid_o, 1'b0);
    compare("rst_req_ready_o", req_ready_o, '0);
    compare("rst_busy_o", busy_o, '0);
    compare("rst_err_o", err_o, 1'b0);
    compare("rst_next_id_o", next_id_o, {N{4'd1}});
    compare("rst_done_id_o", done_id_o, '0);
    @(posedge clk_i);
    #1;
    req_valid_i   = '0;
    req_ready_i   = 1'b0;
    cmpl_valid_i  = 1'b0;
    cmpl_stream_i = '0;
    rst_ni        = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] cur_v;
    rst_ni        = 1'b0;
    req_valid_i   = '0;
    req_ready_i   = 1'b0;
    cmpl_valid_i  = 1'b0;
    cmpl_stream_i = '0;
    for (int s = 0; s < N; s++) req_i[s] = req_t'(16'hA000 + s);

    tbl[0]  = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'd1};
    tbl[1]  = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 4'd1};
    tbl[2]  = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'd1};
    tbl[3]  = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 4'd1};
    tbl[4]  = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'd2};
    tbl[5]  = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 4'd2};
    tbl[6]  = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'd2};
    tbl[7]  = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 4'd2};
    tbl[8]  = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0};
    tbl[9]  = '{4'hF, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'd0};
    tbl[10] = '{4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'd3};

    @(posedge clk_i);
    #1;
    doReset();

    // Round-robin order, per-stream IDs, saturation and release by completion
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].valid, tbl[i].ready, tbl[i].cv, tbl[i].cs);
      compare("tbl_valid", s_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        compare("tbl_grant", s_stream, tbl[i].e_grant);
        compare("tbl_id", s_id, tbl[i].e_id);
      end
    end

    // Stalled grant stays locked even when a stream ahead in the rotation arrives
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0);
      compare("lock_grant_wait", s_stream, 2'd1);
      compare("lock_req_wait", s_req, 16'hA001);
    end
    applyStimulus(4'b0011, 1'b0, 1'b0, 2'd0);
    compare("lock_grant_held", s_stream, 2'd1);
    compare("lock_req_held", s_req, 16'hA001);
    applyStimulus(4'b0011, 1'b1, 1'b0, 2'd0);
    compare("lock_grant_hs", s_stream, 2'd1);
    applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
    compare("lock_after_grant", s_stream, 2'd0);

    // Reset mid-transfer drops the lock and counts; stale completions are illegal
    applyStimulus(4'b0100, 1'b0, 1'b0, 2'd0);
    doReset();
    applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
    compare("post_rst_id", s_id, 4'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1, 2'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
    compare("post_rst_err", s_err, 1'b1);

    // Outstanding limit on stream 2
    doReset();
    applyStimulus(4'b0100, 1'b1, 1'b0, 2'd0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 2'd0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 2'd0);
    compare("max_stall_ready", s_ready[2], 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b1, 2'd2);
    compare("max_cmpl_cycle_ready", s_ready[2], 1'b0);
    compare("max_done_id", done_id_o[2], 4'd1);
    applyStimulus(4'b0100, 1'b1, 1'b0, 2'd0);
    compare("max_resume_ready", s_ready[2], 1'b1);
    compare("max_resume_id", s_id, 4'd3);

    // Handshake and completion on the same stream in one cycle
    doReset();
    applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
    applyStimulus(4'b0001, 1'b1, 1'b1, 2'd0);
    compare("same_next_id", next_id_o[0], 4'd3);
    compare("same_done_id", done_id_o[0], 4'd1);
    compare("same_busy", busy_o[0], 1'b1);
    applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
    compare("same_one_slot_left", s_valid, 1'b1);
    applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
    compare("same_now_full", s_valid, 1'b0);

    // ID wrap skips zero; completion on an idle stream flags an error
    doReset();
    applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(4'b0001, 1'b1, 1'b1, 2'd0);
      if (k == 14) compare("wrap_last_id", s_id, 4'd15);
    end
    compare("wrap_next_id", next_id_o[0], 4'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1, 2'd0);
    compare("wrap_done_id", done_id_o[0], 4'd15);
    applyStimulus(4'b0000, 1'b0, 1'b1, 2'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
    compare("idle_cmpl_err", s_err, 1'b1);
    compare("idle_cmpl_done_id", done_id_o[0], 4'd15);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
    compare("err_one_cycle", s_err, 1'b0);

    // Randomized traffic; a pending request keeps valid and data until accepted
    doReset();
    cur_v   = '0;
    s_ready = '0;
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < N; s++) begin
        if (!(cur_v[s] && !s_ready[s])) begin
          cur_v[s] = ($urandom_range(0, 99) < 60);
          req_i[s] = req_t'($urandom);
        end
      end
      applyStimulus(cur_v, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35,
                    2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
